nrd_result_collector: RTL and testbench

//  Downstream stage of the non-restoring divider array. Accepts raw {R,Q} plus operands X/Y,

---
 rtl/nrd_result_collector_pkg.sv | 27 ++
 rtl/nrd_rem_fix.sv | 40 ++++
 rtl/nrd_result_collector.sv | 159 +++++++++++++++
 tb/tb_nrd_result_collector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nrd_result_collector_pkg.sv
//------------------------------------------------------------------------------
// Module   : nrd_result_collector_pkg
// Brief    : Shared defaults and helpers for the NRD result collector slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package nrd_result_collector_pkg;

    localparam int NRD_WIDTH = 4;
    localparam int NRD_DEPTH = 4;

    // Quotient reported for a zero divisor at the default width.
    localparam logic [NRD_WIDTH-1:0] NRD_DZ_QUOT = '1;

    function automatic int nrd_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nrd_rem_fix.sv
//------------------------------------------------------------------------------
// Module   : nrd_rem_fix
// Brief    : Combinational remainder correction and divide-by-zero handling.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nrd_rem_fix #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH:0]   in_r,
    input  logic [WIDTH-1:0] in_q,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);

    logic [WIDTH:0] w_sum;

    // A negative raw remainder is restored by adding the divisor back once.
    assign w_sum = in_r + {1'b0, in_y};

    always_comb begin
        q   = in_q;
        rem = in_r[WIDTH-1:0];
        dz  = 1'b0;
        if (in_y == '0) begin
            q   = '1;
            rem = in_x;
            dz  = 1'b1;
        end else if (in_r[WIDTH]) begin
            rem = w_sum[WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/nrd_result_collector.sv
//------------------------------------------------------------------------------
// Module   : nrd_result_collector
// Brief    : Corrects raw divider results and buffers them in a small FIFO
//            with valid/ready handshakes. Optional macro NRD_DZ_STATS_EN adds
//            a saturating divide-by-zero counter output dz_cnt.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nrd_result_collector
    import nrd_result_collector_pkg::*;
#(
    parameter int WIDTH = NRD_WIDTH,
    parameter int DEPTH = NRD_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_x,
    input  logic [WIDTH-1:0]              in_y,
    input  logic [WIDTH:0]                in_r,
    input  logic [WIDTH-1:0]              in_q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_q,
    output logic [WIDTH-1:0]              out_rem,
    output logic                          out_dz,
    output logic [nrd_clog2(DEPTH):0]     count
`ifdef NRD_DZ_STATS_EN
    ,
    output logic [7:0]                    dz_cnt
`endif
);

    localparam int PTR_W = nrd_clog2(DEPTH);

    logic [WIDTH-1:0] w_fix_q;
    logic [WIDTH-1:0] w_fix_rem;
    logic             w_fix_dz;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic [WIDTH-1:0] r_mem_q   [DEPTH];
    logic [WIDTH-1:0] r_mem_rem [DEPTH];
    logic             r_mem_dz  [DEPTH];

    logic [WIDTH-1:0] r_out_q;
    logic [WIDTH-1:0] r_out_rem;
    logic             r_out_dz;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W:0]   w_cnt_next;
    logic             w_head_written;

    nrd_rem_fix #(
        .WIDTH (WIDTH)
    ) u_rem_fix (
        .in_x (in_x),
        .in_y (in_y),
        .in_r (in_r),
        .in_q (in_q),
        .q    (w_fix_q),
        .rem  (w_fix_rem),
        .dz   (w_fix_dz)
    );

    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = out_ready & ~w_empty;

    assign w_rd_next = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_cnt_next = r_count;
        if (w_push && !w_pop) begin
            w_cnt_next = r_count + (PTR_W+1)'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_next = r_count - (PTR_W+1)'(1);
        end
    end

    // The slot becoming head may be written this very edge; take it from the fixer.
    assign w_head_written = w_push && (r_wr_ptr == w_rd_next);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                r_mem_q[gi]   <= w_fix_q;
                r_mem_rem[gi] <= w_fix_rem;
                r_mem_dz[gi]  <= w_fix_dz;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_cnt_next;
        end
    end

    // Head registers hold the last popped value while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q   <= '0;
            r_out_rem <= '0;
            r_out_dz  <= 1'b0;
        end else if (w_cnt_next != '0) begin
            if (w_head_written) begin
                r_out_q   <= w_fix_q;
                r_out_rem <= w_fix_rem;
                r_out_dz  <= w_fix_dz;
            end else begin
                r_out_q   <= r_mem_q[w_rd_next];
                r_out_rem <= r_mem_rem[w_rd_next];
                r_out_dz  <= r_mem_dz[w_rd_next];
            end
        end
    end

`ifdef NRD_DZ_STATS_EN
    logic [7:0] r_dz_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dz_cnt <= '0;
        end else if (w_push && w_fix_dz && (r_dz_cnt != 8'hFF)) begin
            r_dz_cnt <= r_dz_cnt + 8'd1;
        end
    end

    assign dz_cnt = r_dz_cnt;
`endif

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign out_q     = r_out_q;
    assign out_rem   = r_out_rem;
    assign out_dz    = r_out_dz;
    assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_nrd_result_collector.sv
//------------------------------------------------------------------------------
// Module   : tb_nrd_result_collector
// Brief    : Directed self-checking bench for nrd_result_collector.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nrd_result_collector;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic [4:0] in_r;
    logic [3:0] in_q;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_q;
    logic [3:0] out_rem;
    logic       out_dz;
    logic [2:0] count;
`ifdef NRD_DZ_STATS_EN
    logic [7:0] dz_cnt;
`endif

    int n_cmp;
    int n_err;

    nrd_result_collector #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_r      (in_r),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_rem   (out_rem),
        .out_dz    (out_dz),
        .count     (count)
`ifdef NRD_DZ_STATS_EN
        ,
        .dz_cnt    (dz_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [3:0] x, input logic [3:0] y,
                        input logic [4:0] r, input logic [3:0] q);
        in_x = x; in_y = y; in_r = r; in_q = q;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_hs: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (out_q !== 4'd0 || out_rem !== 4'd0 || out_dz !== 1'b0) begin
            n_err++; $display("FAIL rst_out: got q=%0d rem=%0d dz=%b want 0/0/0", out_q, out_rem, out_dz);
        end
    endtask

    task automatic test_basic();
        push(4'd6, 4'd2, 5'b00000, 4'd3);
        n_cmp++;
        if (out_valid !== 1'b1 || count !== 3'd1) begin
            n_err++; $display("FAIL basic_valid: got valid=%b count=%0d want 1/1", out_valid, count);
        end
        n_cmp++;
        if (out_q !== 4'd3 || out_rem !== 4'd0 || out_dz !== 1'b0) begin
            n_err++; $display("FAIL basic_data: got q=%0d rem=%0d dz=%b want 3/0/0", out_q, out_rem, out_dz);
        end
        pop();
        n_cmp++;
        if (out_valid !== 1'b0 || out_q !== 4'd3) begin
            n_err++; $display("FAIL basic_hold: got valid=%b q=%0d want 0/3", out_valid, out_q);
        end
    endtask

    task automatic test_neg_rem();
        push(4'd12, 4'd3, 5'b11101, 4'd4);
        n_cmp++;
        if (out_q !== 4'd4 || out_rem !== 4'd0 || out_dz !== 1'b0) begin
            n_err++; $display("FAIL neg_rem0: got q=%0d rem=%0d dz=%b want 4/0/0", out_q, out_rem, out_dz);
        end
        pop();
        push(4'd13, 4'd3, 5'b11110, 4'd4);
        n_cmp++;
        if (out_rem !== 4'd1) begin
            n_err++; $display("FAIL neg_rem1: got rem=%0d want 1", out_rem);
        end
        pop();
        // Positive remainder passes through unchanged.
        push(4'd11, 4'd4, 5'b00011, 4'd2);
        n_cmp++;
        if (out_q !== 4'd2 || out_rem !== 4'd3) begin
            n_err++; $display("FAIL pos_rem: got q=%0d rem=%0d want 2/3", out_q, out_rem);
        end
        pop();
    endtask

    task automatic test_dz();
        do_reset();
        push(4'd13, 4'd0, 5'b10101, 4'd7);
        n_cmp++;
        if (out_q !== 4'hF || out_rem !== 4'd13 || out_dz !== 1'b1) begin
            n_err++; $display("FAIL dz_data: got q=%0d rem=%0d dz=%b want 15/13/1", out_q, out_rem, out_dz);
        end
`ifdef NRD_DZ_STATS_EN
        n_cmp++;
        if (dz_cnt !== 8'd1) begin n_err++; $display("FAIL dz_cnt: got %0d want 1", dz_cnt); end
`endif
        pop();
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL full_ready_%0d: got %b want 1", i, in_ready);
            end
            push(4'(i + 8), 4'd5, 5'(i), 4'(i));
        end
        n_cmp++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL full_state: got count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        push(4'd14, 4'd5, 5'd4, 4'd9);
        n_cmp++;
        if (count !== 3'd4) begin n_err++; $display("FAIL full_reject: got count=%0d want 4", count); end
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_q !== 4'(i) || out_rem !== 4'(i)) begin
                n_err++;
                $display("FAIL drain_%0d: got valid=%b q=%0d rem=%0d want 1/%0d/%0d",
                         i, out_valid, out_q, out_rem, i, i);
            end
            pop();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_q !== 4'd4) begin
            n_err++; $display("FAIL drain_end: got valid=%b count=%0d q=%0d want 0/0/4", out_valid, count, out_q);
        end
    endtask

    task automatic test_back_to_back();
        push(4'd9, 4'd1, 5'd0, 4'd9);
        push(4'd10, 4'd1, 5'd0, 4'd10);
        n_cmp++;
        if (count !== 3'd2 || out_q !== 4'd9) begin
            n_err++; $display("FAIL b2b_pre: got count=%0d q=%0d want 2/9", count, out_q);
        end
        in_x = 4'd11; in_y = 4'd1; in_r = 5'd0; in_q = 4'd11;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (count !== 3'd2 || out_q !== 4'd10) begin
            n_err++; $display("FAIL b2b_post: got count=%0d q=%0d want 2/10", count, out_q);
        end
        pop();
        n_cmp++;
        if (out_q !== 4'd11 || count !== 3'd1) begin
            n_err++; $display("FAIL b2b_last: got q=%0d count=%0d want 11/1", out_q, count);
        end
        pop();
    endtask

    task automatic test_mid_reset();
        push(4'd1, 4'd2, 5'd1, 4'd5);
        push(4'd2, 4'd2, 5'd0, 4'd6);
        push(4'd3, 4'd2, 5'd1, 4'd7);
        n_cmp++;
        if (count !== 3'd3 || out_q !== 4'd5 || out_rem !== 4'd1) begin
            n_err++; $display("FAIL mid_pre: got count=%0d q=%0d rem=%0d want 3/5/1", count, out_q, out_rem);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_rst_hs: got count=%0d valid=%b ready=%b want 0/0/1", count, out_valid, in_ready);
        end
        n_cmp++;
        if (out_q !== 4'd0 || out_rem !== 4'd0 || out_dz !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_out: got q=%0d rem=%0d dz=%b want 0/0/0", out_q, out_rem, out_dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(4'd4, 4'd3, 5'd2, 4'd1);
        n_cmp++;
        if (count !== 3'd1 || out_q !== 4'd1 || out_rem !== 4'd2) begin
            n_err++; $display("FAIL mid_after: got count=%0d q=%0d rem=%0d want 1/1/2", count, out_q, out_rem);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_x = '0; in_y = '0; in_r = '0; in_q = '0;
        test_reset();
        test_basic();
        test_neg_rem();
        test_dz();
        test_full();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
